// File: rtl/serial_to_parallel_word_receiver_pkg.sv
// Shared definitions for the serial word receiver and its matching shift transmitter:
// FSM state codes and the bit-counter width derived from the word width.
package serial_to_parallel_word_receiver_pkg;

  typedef logic [0:0] state_t;

  localparam state_t HUNT    = 1'b0;
  localparam state_t COLLECT = 1'b1;

  // Counter must be able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_to_parallel_word_receiver_word_shift_accumulator.sv
// N-bit shift register that assembles serial bits in MSB-first or LSB-first order.
// sh_d_o is the next-state value, so a completing bit is visible before the edge.
module serial_to_parallel_word_receiver_word_shift_accumulator
  import serial_to_parallel_word_receiver_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en_i,
  input  logic         load_first_i,
  input  logic         bit_i,
  output logic [N-1:0] sh_d_o
);

  logic [N-1:0] sh_q;
  logic [N-1:0] sh_d;
  logic [N-1:0] base;

  // A first bit starts from a cleared register so no stale bits leak into the new word.
  always_comb begin
    base = load_first_i ? '0 : sh_q;
    sh_d = sh_q;
    if (shift_en_i) begin
      if (LSB_FIRST) sh_d = {bit_i, base[N-1:1]};
      else           sh_d = {base[N-2:0], bit_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= sh_d;
  end

  assign sh_d_o = sh_d;

endmodule

// File: rtl/serial_to_parallel_word_receiver.sv
// Reassembles a framed serial bit stream into N-bit words with a one-entry output
// register; valid/ready rule: a word moves downstream on a cycle with out_valid && out_ready.
module serial_to_parallel_word_receiver
  import serial_to_parallel_word_receiver_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_bit,
  input  logic         in_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         overflow,
  output logic         frame_err
);

  localparam int CW = cnt_width(N);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;
  logic          shift_en;
  logic          complete;
  logic [N-1:0]  sh_next;

  serial_to_parallel_word_receiver_word_shift_accumulator #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift_en_i   (shift_en),
    .load_first_i (in_valid && in_first),
    .bit_i        (in_bit),
    .sh_d_o       (sh_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovf_d    = 1'b0;
    ferr_d   = 1'b0;
    complete = 1'b0;
    shift_en = in_valid && (in_first || (state_q == COLLECT));

    // in_first always wins, even on what would have been the completing beat.
    if (in_valid && in_first) begin
      ferr_d  = (state_q == COLLECT);
      state_d = COLLECT;
      cnt_d   = CW'(1);
    end else if (in_valid && (state_q == COLLECT)) begin
      if (cnt_q == CW'(N - 1)) begin
        complete = 1'b1;
        state_d  = HUNT;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (complete) begin
      if (!valid_q || out_ready) begin
        data_d  = sh_next;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_serial_to_parallel_word_receiver.sv
// Bench for the serial word receiver: an MSB-first and an LSB-first instance share one
// serial stream and are compared every cycle against a bit-queue word model.
module tb_serial_to_parallel_word_receiver;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_bit;
  logic         in_first;
  logic         out_ready;
  logic         m_valid, l_valid;
  logic [N-1:0] m_data, l_data;
  logic         m_ovf, l_ovf;
  logic         m_ferr, l_ferr;

  serial_to_parallel_word_receiver #(.N(N), .LSB_FIRST(1'b0)) dut_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_first  (in_first),
    .out_valid (m_valid),
    .out_ready (out_ready),
    .out_data  (m_data),
    .overflow  (m_ovf),
    .frame_err (m_ferr)
  );

  serial_to_parallel_word_receiver #(.N(N), .LSB_FIRST(1'b1)) dut_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_first  (in_first),
    .out_valid (l_valid),
    .out_ready (out_ready),
    .out_data  (l_data),
    .overflow  (l_ovf),
    .frame_err (l_ferr)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: bits of the word in progress (empty = hunting) and the output register
  logic         bits_q[$];
  logic         e_valid;
  logic [N-1:0] e_msb, e_lsb;
  logic         e_ovf, e_ferr;
  logic [N-1:0] got_m[$];
  logic [N-1:0] got_l[$];
  int           n_cmp, n_err;
  int           ovf_seen, ferr_seen;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits_q.delete();
    e_valid = 1'b0;
    e_msb   = '0;
    e_lsb   = '0;
    e_ovf   = 1'b0;
    e_ferr  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs presented for this cycle.
  task automatic model_step();
    logic [N-1:0] wm, wl;
    bit           done;
    done = 1'b0;
    wm   = '0;
    wl   = '0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_valid && out_ready) got_m.push_back(m_data);
    if (l_valid && out_ready) got_l.push_back(l_data);
    e_ovf  = 1'b0;
    e_ferr = 1'b0;
    if (in_valid) begin
      if (in_first) begin
        if (bits_q.size() > 0) e_ferr = 1'b1;
        bits_q.delete();
        bits_q.push_back(in_bit);
      end else if (bits_q.size() > 0) begin
        bits_q.push_back(in_bit);
        if (bits_q.size() == N) begin
          for (int i = 0; i < N; i++) begin
            wm[N-1-i] = bits_q[i];
            wl[i]     = bits_q[i];
          end
          bits_q.delete();
          done = 1'b1;
        end
      end
    end
    if (done) begin
      if (!e_valid || out_ready) begin
        e_valid = 1'b1;
        e_msb   = wm;
        e_lsb   = wl;
      end else begin
        e_ovf = 1'b1;
      end
    end else if (e_valid && out_ready) begin
      e_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("valid_msb", {31'b0, m_valid}, {31'b0, e_valid});
    check("data_msb",  {24'b0, m_data},  {24'b0, e_msb});
    check("ovf_msb",   {31'b0, m_ovf},   {31'b0, e_ovf});
    check("ferr_msb",  {31'b0, m_ferr},  {31'b0, e_ferr});
    check("valid_lsb", {31'b0, l_valid}, {31'b0, e_valid});
    check("data_lsb",  {24'b0, l_data},  {24'b0, e_lsb});
    check("ovf_lsb",   {31'b0, l_ovf},   {31'b0, e_ovf});
    check("ferr_lsb",  {31'b0, l_ferr},  {31'b0, e_ferr});
    ovf_seen  += int'(m_ovf);
    ferr_seen += int'(m_ferr);
  endtask

  // One cycle: model sees the current inputs, the edge passes, outputs are checked mid-low.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_bit   = 1'($urandom_range(0, 1));
      in_first = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic send_bit(input logic b, input logic f);
    in_valid = 1'b1;
    in_bit   = b;
    in_first = f;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit gaps);
    for (int i = N - 1; i >= 0; i--) begin
      send_bit(w[i], i == N - 1);
      if (gaps && i == 4) idle(2);
    end
  endtask

  task automatic clear_logs();
    got_m.delete();
    got_l.delete();
    ovf_seen  = 0;
    ferr_seen = 0;
  endtask

  initial begin
    logic [N-1:0] w02;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_first  = 1'b0;
    out_ready = 1'b1;
    model_reset();
    clear_logs();
    tick();
    tick();
    check("reset_data", {24'b0, m_data}, 32'h0);
    check("reset_valid", {31'b0, m_valid}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Serial 1,0,1,1,0,0,1,0: MSB-first B2, LSB-first 4D
    clear_logs();
    send_word(8'hB2, 1'b0);
    idle(3);
    check("t1_count", got_m.size(), 1);
    check("t1_msb", {24'b0, got_m[0]}, 32'hB2);
    check("t1_lsb", {24'b0, got_l[0]}, 32'h4D);
    check("t1_pulses", ovf_seen + ferr_seen, 0);

    // Held word with no consumer: second word overflows
    clear_logs();
    out_ready = 1'b0;
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    idle(2);
    check("t3_hold", {24'b0, m_data}, 32'hA5);
    check("t3_ovf_count", ovf_seen, 1);
    out_ready = 1'b1;
    idle(3);
    check("t3_count", got_m.size(), 1);
    check("t3_word", {24'b0, got_m[0]}, 32'hA5);

    // Mid-word restart abandons 4 bits
    clear_logs();
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_word(8'hF0, 1'b0);
    idle(3);
    check("t4_ferr_count", ferr_seen, 1);
    check("t4_count", got_m.size(), 1);
    check("t4_msb", {24'b0, got_m[0]}, 32'hF0);
    check("t4_lsb", {24'b0, got_l[0]}, 32'h0F);

    // Hunt-ignored beats, gaps inside a word, completion coinciding with accept
    clear_logs();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    out_ready = 1'b0;
    send_word(8'h01, 1'b1);
    w02 = 8'h02;
    for (int i = N - 1; i >= 0; i--) begin
      if (i == 0) out_ready = 1'b1;
      send_bit(w02[i], i == N - 1);
    end
    send_word(8'h03, 1'b0);
    idle(3);
    check("t5_count", got_m.size(), 3);
    check("t5_w0", {24'b0, got_m[0]}, 32'h01);
    check("t5_w1", {24'b0, got_m[1]}, 32'h02);
    check("t5_w2", {24'b0, got_m[2]}, 32'h03);
    check("t5_lsb_w2", {24'b0, got_l[2]}, 32'hC0);
    check("t5_ovf", ovf_seen, 0);

    // Reset in the middle of a word
    clear_logs();
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    rst_n = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_word(8'h81, 1'b0);
    idle(3);
    check("t6_count", got_m.size(), 1);
    check("t6_word", {24'b0, got_m[0]}, 32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_word_receiver.md
# serial_to_parallel_word_receiver

Receives a serial bit stream and reassembles it into N-bit parallel words, framed by a start-of-word marker. It is the receive end of the team's parallel-to-serial shift transmitter: bits shifted out one per accepted cycle are shifted back in here. Completed words go to a downstream consumer over a valid/ready handshake. The serial side has no backpressure, so overruns and framing faults are reported as one-cycle pulses.

## Interface

Parameters:
- N, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = first serial bit lands in out_data[N-1] (MSB-first); 1 = first serial bit lands in out_data[0].

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  in_bit is meaningful this cycle.
- in_bit  input  1  serial data bit.
- in_first  input  1  qualified by in_valid; marks the first bit of a word.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  N  assembled word; held stable while out_valid && !out_ready.
- overflow  output  1  one-cycle pulse: a completed word was dropped.
- frame_err  output  1  one-cycle pulse: a partial word was abandoned.

## Operation

- Reset values: state HUNT, bit counter 0, shift register 0, out_data 0, out_valid 0, overflow 0, frame_err 0.
- FSM HUNT:
  - In HUNT, beats with in_valid && !in_first are ignored.
  - A beat with in_valid && in_first shifts the bit in, sets the counter to 1, and moves the FSM to COLLECT.
- FSM COLLECT:
  - Each in_valid beat shifts one bit in and increments the counter.
  - The beat that brings the counter to N completes the word. The FSM returns to HUNT and the counter clears to 0.
- Mid-word restart: an in_first beat while in COLLECT with counter > 0 abandons the partial word and pulses frame_err. That beat is taken as bit 0 of a new word, so the counter becomes 1 and the FSM stays in COLLECT.
- Shift rules:
  - MSB-first: sh <= {sh[N-2:0], in_bit}.
  - LSB-first: sh <= {in_bit, sh[N-1:1]}.
  - On completion the full N-bit pattern, including the completing bit, is presented.
- Output holding register: one entry.
  - On completion, if !out_valid or (out_valid && out_ready), load out_data and set out_valid = 1.
  - Otherwise, drop the new word, keep the old out_data unchanged, and pulse overflow.
  - If out_valid && out_ready and no completion, clear out_valid. out_data keeps its last value.
- N = 1 is not supported. Counter width is $clog2(N+1).

## Timing

- Latency: out_valid rises on the edge that samples the Nth in_valid beat. It is visible the cycle after that beat is presented.
- Back-to-back words with in_valid held high and out_ready held high give one word every N cycles with no gap.
- Simultaneous completion and handshake accept: the old word is consumed, the new word is loaded, and out_valid stays 1. No overflow.
- overflow and frame_err are registered. Each is high for exactly the cycle after the triggering beat.
- Completion of bit N with in_first set at the same time (N-th beat marked first): this counts as a restart. The partial word is abandoned, frame_err pulses, and no word is output.
- Reset asserted mid-word or with out_valid high: everything returns to reset values immediately. Held data is lost. The first post-reset word requires in_first.
- in_bit and in_first are don't-care when in_valid = 0. The counter holds.

## Structure

- Shared package: the FSM state enum (HUNT, COLLECT) and a counter-width function/constant derived from N. The transmitter imports the same package.
- One sub-module, word_shift_accumulator. It holds the N-bit shift register and the LSB_FIRST mux, with a shift enable and a load-first control. The FSM, the holding register and the error pulses stay in the top module.

## Test plan

- MSB-first, N=8, out_ready=1. Serial 1,0,1,1,0,0,1,0 with in_first on the first bit -> one beat of out_valid with out_data = 8'hB2, no pulses.
- LSB-first, N=8. Same bit sequence -> out_data = 8'h4D.
- out_ready=0. Send word 8'hA5, then word 8'h3C -> out_data stays 8'hA5 and overflow pulses once, one cycle after 8'h3C's last bit. Raising out_ready then delivers 8'hA5 only.
- Send 4 bits, then in_first followed by word 8'hF0 -> frame_err pulses one cycle after the second in_first, then 8'hF0 is delivered.
- Beats without in_first while in HUNT, in_valid gaps inside a word, and simultaneous completion with accept on continuous 8'h01, 8'h02, 8'h03 -> ignored bits produce nothing, and the three words come out in order with no overflow.
- Assert rst_n low after 5 bits of a word, release, send 8'h81 -> all outputs 0 during reset, then 8'h81 is delivered and no stale bits are mixed in.
